ingress_frame_writer: RTL and testbench
=======================================

Name: ingress_frame_writer

Overview:
- Ingress side of the 3-port switch: accepts a framed symbol stream from one input link and writes it into that port's input FIFO.
- The crossbar scheduler reads that FIFO from the other end.
- Tags every FIFO word with the 2-bit output-port code in bits [1:0], which is the field the scheduler arbitrates on.
- Resolves the destination from the frame's header symbol through a programmable 16-entry station table, applies backpressure when the FIFO is full, and drops frames with unknown destinations.

Parameters:
SYM_W, 6, payload symbol width; FIFO word width is SYM_W+2 (8 at default)
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
in_valid  input  1  input symbol valid
in_ready  output  1  writer can accept the symbol this cycle
in_sop  input  1  first symbol of frame (header); bits [3:0] = station address
in_eop  input  1  last symbol of frame
in_data  input  SYM_W  symbol
fifo_full  input  1  input FIFO full
fifo_wrreq  output  1  FIFO write strobe
fifo_data  output  SYM_W+2  {symbol, port_code[1:0]}
cfg_we  input  1  station table write enable
cfg_addr  input  4  station table index
cfg_code  input  2  port code: 01/10/11 = output 1/2/3, 00 = unreachable
frames_fwd  output  CNT_W  frames fully forwarded
frames_drop  output  CNT_W  frames dropped (code 00)
frames_err  output  CNT_W  frames aborted by a missing eop

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, latched code=00, all 16 table entries=00, all counters=0.
- During reset, in_ready=0 and fifo_wrreq=0.
- Accepted beat = in_valid & in_ready.
- fifo_wrreq and fifo_data are combinational from the current inputs and state, so there is zero latency and a write never occurs while fifo_full=1.
- Lookup: code = table[in_data[3:0]] on a sop beat. The table read sees the pre-write contents when cfg_we targets the same entry in the same cycle. The new value applies from the next cycle.
- A latched code is held for the rest of the frame. Table writes during a frame do not affect that frame.
- FSM states: IDLE, FWD, DROP.
- IDLE, no sop: in_ready=1, the beat is discarded, no write, no counter change.
- IDLE, sop, code!=00:
  - in_ready=!fifo_full.
  - When accepted: write {in_data, code}, latch code.
  - Go to FWD, or stay IDLE and increment frames_fwd if eop is set on the same beat.
  - While fifo_full=1 the header stalls (in_ready=0, no state change).
- IDLE, sop, code==00: in_ready=1, no write. Go to DROP, or stay IDLE if eop is set; frames_drop increments when the frame's eop is accepted.
- FWD: in_ready=!fifo_full. Each accepted beat writes {in_data, latched code}. Accepted eop: go to IDLE, frames_fwd+1.
- DROP: in_ready=1, no writes. Accepted eop: go to IDLE, frames_drop+1.
- sop while in FWD or DROP (missing eop): frames_err+1 and the aborted frame is not counted elsewhere. The beat is then processed exactly as an IDLE sop beat in the same cycle, including stall, write and state selection.
- In FWD with fifo_full=1 and an incoming sop, in_ready=0 when the new code!=00. frames_err increments only when that beat is accepted.
- Counters saturate at all-ones and do not wrap.
- fifo_data bits [1:0] are never 00 when fifo_wrreq=1.

Test Plan:
- Program table[5]=10. Send a 4-symbol frame (header 0x05, then 0x11, 0x22, eop 0x33) with fifo_full=0 -> 4 writes, fifo_data=0x16,0x46,0x8A,0xCE in consecutive cycles; frames_fwd=1.
- Send a frame to station 9 (table entry 00), 3 symbols -> no fifo_wrreq, in_ready stays 1, frames_drop=1, state returns to IDLE.
- Forward to table[2]=11 with fifo_full asserted for 3 cycles after the second symbol -> in_ready=0 for those 3 cycles, the symbol is held and written exactly once after full deasserts, order is preserved, no lost or duplicated words.
- Send a single-beat frame (sop & eop) to table[1]=01 -> one write with low bits 01, frames_fwd+1, FSM remains IDLE.
- Mid-frame (FWD) sop to station 5 without a preceding eop -> frames_err=1, new header written with code 10, FSM in FWD.
- cfg_we writes table[5]=01 in the same cycle as a header to station 5 (old value 10) -> frame tagged 10 throughout; the next frame to station 5 is tagged 01.
- Assert reset_n=0 mid-frame in FWD -> next cycle in_ready=0, no write, counters=0, table cleared. After release, non-sop beats are discarded until a sop arrives.

Source files
------------

// File: rtl/ingress_frame_writer.sv
// ingress_frame_writer
// Ingress side of one switch port: takes a framed symbol stream from the
// input link and writes it into this port's input FIFO. Every FIFO word is
// tagged with the 2-bit output-port code in bits [1:0]. The crossbar scheduler
// arbitrates on that code.
//
// Destination resolution uses a programmable 16-entry station table indexed
// by the header symbol's low nibble. Frames whose station maps to code 00 are
// swallowed and counted as drops. A header seen while a frame is still open
// aborts that frame (counted as an error). The header is then handled as a
// fresh header in the same cycle.
//
// Handshake: a beat moves when in_valid & in_ready are both high at a rising
// clk edge. in_ready may depend combinationally on fifo_full and on the
// header's table lookup. The producer must hold the beat stable until it is
// accepted. fifo_wrreq is combinational and is never asserted while fifo_full
// is high.
//
// The FSM state is exported on state_dbg (0 = IDLE, 1 = FWD, 2 = DROP).

module ingress_frame_writer #(
  parameter int SYM_W = 6,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [SYM_W-1:0]   in_data,
  input  logic               fifo_full,
  output logic               fifo_wrreq,
  output logic [SYM_W+1:0]   fifo_data,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [1:0]         cfg_code,
  output logic [CNT_W-1:0]   frames_fwd,
  output logic [CNT_W-1:0]   frames_drop,
  output logic [CNT_W-1:0]   frames_err,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   code_q;
  logic [1:0]   code_tbl [16];
  logic [1:0]   lookup_code;
  logic         beat_acc;

  // Saturating increment: a statistics counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign state_dbg = state;
  assign beat_acc  = in_valid & in_ready;

  // Handshake and FIFO write path. A sop beat always goes through the table
  // lookup, whatever the state, because it opens a new frame. The table read
  // here sees the pre-write contents when cfg_we targets the same entry.
  always_comb begin
    lookup_code = code_tbl[in_data[3:0]];
    in_ready    = 1'b0;
    fifo_wrreq  = 1'b0;
    fifo_data   = {in_data, code_q};
    if (reset_n) begin
      if (in_sop) begin
        fifo_data = {in_data, lookup_code};
        if (lookup_code != 2'b00) begin
          in_ready   = !fifo_full;
          fifo_wrreq = in_valid & !fifo_full;
        end else begin
          in_ready = 1'b1;
        end
      end else if (state == S_FWD) begin
        in_ready   = !fifo_full;
        fifo_wrreq = in_valid & !fifo_full;
      end else begin
        // IDLE (stray non-sop beats) and DROP both sink beats silently.
        in_ready = 1'b1;
      end
    end
  end

  // Frame FSM, latched port code, station table and statistics counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      code_q      <= 2'b00;
      frames_fwd  <= '0;
      frames_drop <= '0;
      frames_err  <= '0;
      for (int i = 0; i < 16; i++) code_tbl[i] <= 2'b00;
    end else begin
      if (cfg_we) code_tbl[cfg_addr] <= cfg_code;

      if (beat_acc) begin
        if (in_sop) begin
          // A header inside an open frame aborts that frame.
          if (state != S_IDLE) frames_err <= sat_inc(frames_err);
          code_q <= lookup_code;
          if (lookup_code != 2'b00) begin
            if (in_eop) begin
              state      <= S_IDLE;
              frames_fwd <= sat_inc(frames_fwd);
            end else begin
              state <= S_FWD;
            end
          end else begin
            if (in_eop) begin
              state       <= S_IDLE;
              frames_drop <= sat_inc(frames_drop);
            end else begin
              state <= S_DROP;
            end
          end
        end else begin
          case (state)
            S_FWD: begin
              if (in_eop) begin
                state      <= S_IDLE;
                frames_fwd <= sat_inc(frames_fwd);
              end
            end
            S_DROP: begin
              if (in_eop) begin
                state       <= S_IDLE;
                frames_drop <= sat_inc(frames_drop);
              end
            end
            default: begin
              // Non-sop beats outside a frame are discarded.
              state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ingress_frame_writer.sv
// Bench for ingress_frame_writer: directed scenarios followed by random
// traffic. Expected handshake, FIFO words and counters come from a
// frame-level reference model.
`timescale 1ns/1ps

module tb_ingress_frame_writer;

  localparam int SYM_W = 6;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_sop = 1'b0;
  logic               in_eop = 1'b0;
  logic [SYM_W-1:0]   in_data = '0;
  logic               fifo_full = 1'b0;
  logic               fifo_wrreq;
  logic [SYM_W+1:0]   fifo_data;
  logic               cfg_we = 1'b0;
  logic [3:0]         cfg_addr = '0;
  logic [1:0]         cfg_code = '0;
  logic [CNT_W-1:0]   frames_fwd;
  logic [CNT_W-1:0]   frames_drop;
  logic [CNT_W-1:0]   frames_err;
  logic [1:0]         state_dbg;

  ingress_frame_writer #(.SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_code(cfg_code),
    .frames_fwd(frames_fwd), .frames_drop(frames_drop), .frames_err(frames_err),
    .state_dbg(state_dbg)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [SYM_W+1:0] exp_q[$];
  logic [SYM_W+1:0] wr_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: which frame is open (none / being forwarded / being
  // dropped), the port code it travels under, the station table, counters
  localparam int F_NONE = 0, F_FWD = 1, F_DROP = 2;
  int         m_frame;
  logic [1:0] m_code;
  logic [1:0] m_tbl [16];
  int         m_fwd, m_drop, m_err;

  function automatic int bump(input int v);
    return (v >= CMAX) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_frame = F_NONE;
    m_code  = 2'b00;
    for (int i = 0; i < 16; i++) m_tbl[i] = 2'b00;
    m_fwd = 0; m_drop = 0; m_err = 0;
  endtask

  // driver: one clock of stimulus, checked before and after the edge
  task automatic beat(input bit rst_n, input bit v, input bit sop, input bit eop,
                      input logic [SYM_W-1:0] d, input bit full,
                      input bit we, input logic [3:0] a, input logic [1:0] c);
    bit               e_ready, e_wr, acc;
    logic [1:0]       hdr_code;
    logic [SYM_W+1:0] e_word, w;
    @(negedge clk);
    reset_n = rst_n; in_valid = v; in_sop = sop; in_eop = eop; in_data = d;
    fifo_full = full; cfg_we = we; cfg_addr = a; cfg_code = c;
    #1;
    hdr_code = m_tbl[d[3:0]];
    e_word   = '0;
    if (!rst_n) begin
      e_ready = 0; e_wr = 0;
    end else if (sop && hdr_code != 2'b00) begin
      e_ready = !full; e_wr = v && !full; e_word = {d, hdr_code};
    end else if (!sop && m_frame == F_FWD) begin
      e_ready = !full; e_wr = v && !full; e_word = {d, m_code};
    end else begin
      e_ready = 1; e_wr = 0;
    end
    check("in_ready", in_ready, e_ready);
    check("fifo_wrreq", fifo_wrreq, e_wr);
    if (e_wr) exp_q.push_back(e_word);
    if (fifo_wrreq) begin
      check("write_expected", exp_q.size() != 0, 1);
      check("full_write", fifo_full, 0);
      check("code_nonzero", fifo_data[1:0] != 2'b00, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("fifo_data", fifo_data, w);
      end
      wr_log.push_back(fifo_data);
    end
    @(posedge clk);
    acc = v && e_ready;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (acc && sop) begin
        if (m_frame != F_NONE) m_err = bump(m_err);
        m_code = hdr_code;
        if (hdr_code != 2'b00) begin
          if (eop) begin m_fwd = bump(m_fwd); m_frame = F_NONE; end
          else m_frame = F_FWD;
        end else begin
          if (eop) begin m_drop = bump(m_drop); m_frame = F_NONE; end
          else m_frame = F_DROP;
        end
      end else if (acc && eop && m_frame == F_FWD) begin
        m_fwd = bump(m_fwd); m_frame = F_NONE;
      end else if (acc && eop && m_frame == F_DROP) begin
        m_drop = bump(m_drop); m_frame = F_NONE;
      end
      if (we) m_tbl[a] = c;
    end
    #1;
    check("frames_fwd", frames_fwd, m_fwd);
    check("frames_drop", frames_drop, m_drop);
    check("frames_err", frames_err, m_err);
    check("state", state_dbg, m_frame);
  endtask

  task automatic send(input bit v, input bit sop, input bit eop,
                      input logic [SYM_W-1:0] d, input bit full);
    beat(1'b1, v, sop, eop, d, full, 1'b0, 4'd0, 2'd0);
  endtask

  task automatic cfg(input logic [3:0] a, input logic [1:0] c);
    beat(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, a, c);
  endtask

  logic [SYM_W+1:0] exp_words [4];

  initial begin
    model_reset();
    exp_words[0] = 8'h16; exp_words[1] = 8'h46; exp_words[2] = 8'h8A; exp_words[3] = 8'hCE;

    // reset
    repeat (3) beat(1'b0, 1'b1, 1'b1, 1'b0, 6'h05, 1'b0, 1'b0, 4'd0, 2'd0);

    // 4-symbol frame to station 5 (code 10)
    cfg(4'd5, 2'b10);
    wr_log.delete();
    send(1, 1, 0, 6'h05, 0);
    send(1, 0, 0, 6'h11, 0);
    send(1, 0, 0, 6'h22, 0);
    send(1, 0, 1, 6'h33, 0);
    check("t1_count", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check("t1_word", wr_log[i], exp_words[i]);
    check("t1_fwd", frames_fwd, 1);

    // frame to unreachable station 9
    wr_log.delete();
    send(1, 1, 0, 6'h09, 0);
    send(1, 0, 0, 6'h2A, 0);
    send(1, 0, 1, 6'h15, 0);
    check("t2_nowrite", wr_log.size(), 0);
    check("t2_drop", frames_drop, 1);

    // backpressure mid-frame to station 2 (code 11)
    cfg(4'd2, 2'b11);
    wr_log.delete();
    send(1, 1, 0, 6'h02, 0);
    send(1, 0, 0, 6'h0A, 0);
    repeat (3) send(1, 0, 0, 6'h0B, 1);
    send(1, 0, 0, 6'h0B, 0);
    send(1, 0, 1, 6'h0C, 0);
    check("t3_count", wr_log.size(), 4);
    if (wr_log.size() == 4) check("t3_held", wr_log[2], {6'h0B, 2'b11});

    // single-beat frame to station 1 (code 01)
    cfg(4'd1, 2'b01);
    wr_log.delete();
    send(1, 1, 1, 6'h01, 0);
    check("t4_count", wr_log.size(), 1);
    if (wr_log.size() == 1) check("t4_code", wr_log[0][1:0], 2'b01);
    check("t4_fwd", frames_fwd, 3);

    // header inside an open frame aborts it
    send(1, 1, 0, 6'h05, 0);
    send(1, 0, 0, 6'h07, 0);
    send(1, 1, 0, 6'h05, 0);
    check("t5_err", frames_err, 1);
    check("t5_state", state_dbg, 1);
    send(1, 0, 1, 6'h08, 0);

    // table write racing a header: old code for this frame, new for next
    wr_log.delete();
    beat(1'b1, 1, 1, 0, 6'h05, 0, 1'b1, 4'd5, 2'b01);
    send(1, 0, 1, 6'h3F, 0);
    send(1, 1, 1, 6'h05, 0);
    check("t6_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("t6_old0", wr_log[0][1:0], 2'b10);
      check("t6_old1", wr_log[1][1:0], 2'b10);
      check("t6_new", wr_log[2][1:0], 2'b01);
    end

    // reset mid-frame, then stray beats until the next header
    send(1, 1, 0, 6'h05, 0);
    send(1, 0, 0, 6'h11, 0);
    beat(1'b0, 1, 0, 0, 6'h12, 0, 1'b0, 4'd0, 2'd0);
    check("t7_fwd", frames_fwd, 0);
    check("t7_err", frames_err, 0);
    send(1, 0, 0, 6'h13, 0);
    send(1, 0, 1, 6'h14, 0);
    send(1, 1, 1, 6'h05, 0);
    check("t7_cleared", frames_drop, 1);

    // random traffic
    for (int i = 0; i < 16; i++) cfg(i[3:0], 2'($urandom_range(0, 3)));
    for (int i = 0; i < 3000; i++) begin
      beat($urandom_range(0, 199) != 0,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 3) == 0,
           6'($urandom_range(0, 63)),
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0,
           4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)));
    end
    send(0, 0, 0, '0, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
